// File: rtl/bcd_entry_loader_pkg.sv
// Shared types and constants for the front-panel BCD entry loader.
// Holds the FSM encoding, decimal digit geometry and small arithmetic helpers.
package bcd_entry_loader_pkg;

  typedef enum logic [1:0] {
    ST_EDIT    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_OFFER   = 2'd2
  } state_e;

  localparam int BCD_W = 4;
  localparam int RADIX = 10;

  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
    return (d == BCD_W'(RADIX - 1)) ? '0 : d + BCD_W'(1);
  endfunction

  function automatic int unsigned sat_val(input int unsigned v, input int unsigned ceil);
    return (v > ceil) ? ceil : v;
  endfunction

endpackage

// File: rtl/bcd_entry_loader_if.sv
// Panel-side pulses, displayed digits and the load handshake toward the counter.
// The master modport is the stimulus/consumer side; the loader uses the slave modport.
interface bcd_entry_loader_if
  import bcd_entry_loader_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);
  localparam int AW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                      inc_pulse;
  logic                      sel_pulse;
  logic                      enter_pulse;
  logic                      load_ready;
  logic [BCD_W*DIGITS-1:0]   digit_bcd;
  logic [AW-1:0]             active_digit;
  logic                      load_valid;
  logic [BIN_W-1:0]          load_value;
  logic                      busy;

  modport master (
    output inc_pulse, sel_pulse, enter_pulse, load_ready,
    input  digit_bcd, active_digit, load_valid, load_value, busy
  );

  modport slave (
    input  inc_pulse, sel_pulse, enter_pulse, load_ready,
    output digit_bcd, active_digit, load_valid, load_value, busy
  );

endinterface

// File: rtl/bcd_entry_loader_bcd_to_bin_serial.sv
// Serial BCD-to-binary converter: one digit per clock, most significant first.
// done_o/result_o are combinational on the final step so the parent can register them.
module bcd_to_bin_serial
  import bcd_entry_loader_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int ACC_W  = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [BCD_W*DIGITS-1:0] snap_i,
  output logic                    done_o,
  output logic [ACC_W-1:0]        result_o
);
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [BCD_W*DIGITS-1:0] snap_q;
  logic [ACC_W-1:0]        acc_q;
  logic [SW-1:0]           step_q;
  logic                    run_q;
  logic [BCD_W-1:0]        cur_digit;

  // The snapshot shifts left each step, so the digit in use is always the top nibble.
  assign cur_digit = snap_q[BCD_W*DIGITS-1 -: BCD_W];
  assign result_o  = (acc_q << 3) + (acc_q << 1) + ACC_W'(cur_digit);
  assign done_o    = run_q && (step_q == SW'(DIGITS - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
      acc_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
    end else if (start_i) begin
      snap_q <= snap_i;
      acc_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      acc_q  <= result_o;
      snap_q <= snap_q << BCD_W;
      step_q <= step_q + SW'(1);
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bcd_entry_loader.sv
// Front-panel decimal entry: edits BCD digits, converts on enter, offers the
// saturated binary result to the counter preload over valid/ready.
module bcd_entry_loader
  import bcd_entry_loader_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int BIN_W   = 7,
  parameter int MAX_VAL = 99
) (
  input logic               clk,
  input logic               rst,
  bcd_entry_loader_if.slave bus
);
  localparam int AW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW    = BCD_W * DIGITS;
  localparam int ACC_W = $clog2(RADIX ** DIGITS);

  state_e             state_q, state_d;
  logic [DW-1:0]      digits_q, digits_d;
  logic [AW-1:0]      active_q, active_d;
  logic               load_valid_q, load_valid_d;
  logic [BIN_W-1:0]   load_value_q, load_value_d;
  logic               conv_start;
  logic               conv_done;
  logic [ACC_W-1:0]   conv_result;

  bcd_to_bin_serial #(
    .DIGITS (DIGITS),
    .ACC_W  (ACC_W)
  ) u_conv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (conv_start),
    .snap_i   (digits_q),
    .done_o   (conv_done),
    .result_o (conv_result)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    digits_d     = digits_q;
    active_d     = active_q;
    load_valid_d = load_valid_q;
    load_value_d = load_value_q;
    conv_start   = 1'b0;
    case (state_q)
      ST_EDIT: begin
        if (bus.enter_pulse) begin
          conv_start = 1'b1;
          state_d    = ST_CONVERT;
        end else begin
          // inc edits the pre-advance digit even when sel arrives in the same cycle.
          if (bus.inc_pulse) begin
            for (int k = 0; k < DIGITS; k++) begin
              if (active_q == AW'(k))
                digits_d[BCD_W*k +: BCD_W] = bcd_inc(digits_q[BCD_W*k +: BCD_W]);
            end
          end
          if (bus.sel_pulse)
            active_d = (active_q == AW'(DIGITS - 1)) ? '0 : active_q + AW'(1);
        end
      end
      ST_CONVERT: begin
        if (conv_done) begin
          load_value_d = BIN_W'(sat_val(32'(conv_result), 32'(MAX_VAL)));
          load_valid_d = 1'b1;
          state_d      = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (bus.load_ready) begin
          load_valid_d = 1'b0;
          state_d      = ST_EDIT;
        end
      end
      default: state_d = ST_EDIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EDIT;
      digits_q     <= '0;
      active_q     <= '0;
      load_valid_q <= 1'b0;
      load_value_q <= '0;
    end else begin
      state_q      <= state_d;
      digits_q     <= digits_d;
      active_q     <= active_d;
      load_valid_q <= load_valid_d;
      load_value_q <= load_value_d;
    end
  end

  assign bus.digit_bcd    = digits_q;
  assign bus.active_digit = active_q;
  assign bus.load_valid   = load_valid_q;
  assign bus.load_value   = load_value_q;
  assign bus.busy         = (state_q != ST_EDIT);

endmodule

// File: tb/tb_bcd_entry_loader.sv
// Directed bench: a per-cycle vector table for the 2-digit loader plus hand-written
// sequences for reset during conversion and 3-digit saturation.
module tb_bcd_entry_loader;

  typedef struct {
    logic       rst;
    logic       inc;
    logic       sel;
    logic       enter;
    logic       ready;
    logic [7:0] digits;
    logic       act;
    logic       valid;
    logic [6:0] value;
    logic       busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  bcd_entry_loader_if #(.DIGITS(2), .BIN_W(7)) bus0 ();
  bcd_entry_loader_if #(.DIGITS(3), .BIN_W(7)) bus1 ();

  bcd_entry_loader #(.DIGITS(2), .BIN_W(7), .MAX_VAL(99)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  bcd_entry_loader #(.DIGITS(3), .BIN_W(7), .MAX_VAL(127)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic i, input logic s, input logic e,
                              input logic rd, input logic [7:0] dg, input logic a,
                              input logic vl, input logic [6:0] val, input logic b);
    vec_t v;
    v.rst = r; v.inc = i; v.sel = s; v.enter = e; v.ready = rd;
    v.digits = dg; v.act = a; v.valid = vl; v.value = val; v.busy = b;
    return v;
  endfunction

  function automatic logic [31:0] pack0();
    return 32'({bus0.digit_bcd, bus0.active_digit, bus0.load_valid, bus0.load_value, bus0.busy});
  endfunction

  task automatic drive0(input logic i, input logic s, input logic e, input logic rd);
    bus0.inc_pulse   = i;
    bus0.sel_pulse   = s;
    bus0.enter_pulse = e;
    bus0.load_ready  = rd;
  endtask

  task automatic drive1(input logic i, input logic s, input logic e, input logic rd);
    bus1.inc_pulse   = i;
    bus1.sel_pulse   = s;
    bus1.enter_pulse = e;
    bus1.load_ready  = rd;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive0(1'b1, 1'b1, 1'b1, 1'b1);
    bus1.inc_pulse = 1'b0; bus1.sel_pulse = 1'b0; bus1.enter_pulse = 1'b0; bus1.load_ready = 1'b0;
    tick();
    tick();
    check("reset_with_pulses", pack0(), 32'd0);
    check("reset_dut1", 32'({bus1.digit_bcd, bus1.active_digit, bus1.load_valid, bus1.busy}), 32'd0);
    rst = 1'b0;
    drive0(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("idle_after_reset", pack0(), 32'd0);

    // Nominal entry of 47 and handshake with ready held high.
    for (int i = 1; i <= 7; i++) vecs.push_back(mk(0, 1, 0, 0, 0, 8'(i), 0, 0, 7'd0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h07, 1, 0, 7'd0, 0));
    for (int k = 1; k <= 4; k++) vecs.push_back(mk(0, 1, 0, 0, 0, {4'(k), 4'h7}, 1, 0, 7'd0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 8'h47, 1, 0, 7'd0,  1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h47, 1, 0, 7'd0,  1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h47, 1, 1, 7'd47, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h47, 1, 0, 7'd47, 0));
    // Reset, then digit and pointer wrap-around.
    vecs.push_back(mk(1, 1, 1, 1, 1, 8'h00, 0, 0, 7'd0, 0));
    for (int i = 1; i <= 10; i++) vecs.push_back(mk(0, 1, 0, 0, 0, 8'(i % 10), 0, 0, 7'd0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 1, 0, 7'd0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 0, 0, 7'd0, 0));
    // inc+sel collision, then backpressure with dropped pulses.
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'h01, 1, 0, 7'd0,  0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h11, 1, 0, 7'd0,  0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h11, 1, 0, 7'd0,  1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h11, 1, 0, 7'd0,  1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h11, 1, 1, 7'd11, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h11, 1, 1, 7'd11, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'h11, 1, 1, 7'd11, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h11, 1, 1, 7'd11, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h11, 1, 1, 7'd11, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h11, 1, 0, 7'd11, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h11, 1, 0, 7'd11, 0));
    // enter+inc collision: inc dropped, conversion runs.
    vecs.push_back(mk(0, 1, 0, 1, 0, 8'h11, 1, 0, 7'd11, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h11, 1, 0, 7'd11, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h11, 1, 1, 7'd11, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h11, 1, 0, 7'd11, 0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      drive0(vecs[i].inc, vecs[i].sel, vecs[i].enter, vecs[i].ready);
      tick();
      check($sformatf("vec%0d", i), pack0(),
            32'({vecs[i].digits, vecs[i].act, vecs[i].valid, vecs[i].value, vecs[i].busy}));
    end
    rst = 1'b0;
    drive0(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset on the first conversion step: nothing must ever be offered.
    drive0(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("convert_started", 32'(bus0.busy), 32'd1);
    drive0(1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    check("reset_mid_convert", pack0(), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("no_valid_after_reset%0d", i), 32'({bus0.load_valid, bus0.busy}), 32'd0);
    end
    drive0(1'b0, 1'b0, 1'b0, 1'b0);

    // Three-digit instance: enter 999, saturates at 127 after three cycles.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 9; i++) drive1(1'b1, 1'b0, 1'b0, 1'b0);
      drive1(1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("d1_digits_999", 32'({bus1.digit_bcd, bus1.active_digit}), 32'({12'h999, 2'd0}));
    drive1(1'b0, 1'b0, 1'b1, 1'b0);
    check("d1_enter", 32'({bus1.load_valid, bus1.busy}), 32'b01);
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    check("d1_step1", 32'({bus1.load_valid, bus1.busy}), 32'b01);
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    check("d1_step2", 32'({bus1.load_valid, bus1.busy}), 32'b01);
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    check("d1_offer", 32'({bus1.load_valid, bus1.load_value, bus1.busy}), 32'({1'b1, 7'd127, 1'b1}));
    drive1(1'b0, 1'b0, 1'b0, 1'b1);
    check("d1_accept", 32'({bus1.load_valid, bus1.load_value, bus1.busy}), 32'({1'b0, 7'd127, 1'b0}));
    drive1(1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_entry_loader.md
Name: bcd_entry_loader

Overview:
- Front-panel value entry: the user dials a multi-digit decimal number with debounced button pulses, one BCD digit at a time.
- On enter, the digits are converted serially to binary (BCD-to-binary; the counter datapath goes binary-to-BCD).
- The result is offered to a counter/loader over a valid/ready handshake.
- Sits between the one-shot button conditioners and the counter preload input; digit_bcd drives the existing 7-segment BCD decoders directly.

Parameters:
- DIGITS, 2, number of BCD digits entered; digit 0 = units, digit DIGITS-1 = most significant.
- BIN_W, 7, width of load_value.
- MAX_VAL, 99, saturation ceiling for load_value; must fit in BIN_W bits.

Ports:
- clk  in  1  system clock (divided clock domain, same as one-shot outputs).
- rst  in  1  synchronous, active-high reset.
- inc_pulse  in  1  one-cycle pulse: increment the active digit.
- sel_pulse  in  1  one-cycle pulse: advance the active-digit pointer.
- enter_pulse  in  1  one-cycle pulse: commit and convert.
- load_ready  in  1  consumer accepts load_value this cycle.
- digit_bcd  out  4*DIGITS  current digits, digit k at bits [4k+3:4k].
- active_digit  out  clog2(DIGITS) (min 1)  index of the digit being edited.
- load_valid  out  1  load_value is valid.
- load_value  out  BIN_W  converted, saturated binary value.
- busy  out  1  high in CONVERT or OFFER.

Behaviour:
- Reset (rst high at an edge): state EDIT; all digits 0; active_digit 0; load_valid 0; load_value 0; busy 0. Reset overrides all other inputs in any state, including mid-CONVERT and mid-OFFER.
- States: EDIT, CONVERT, OFFER.
- EDIT, priority per cycle:
  - enter_pulse: snapshot digits, clear accumulator and step counter, go to CONVERT. inc and sel are ignored that cycle.
  - Otherwise inc_pulse: active digit becomes (d==9 ? 0 : d+1).
  - Otherwise sel_pulse: active_digit becomes (a==DIGITS-1 ? 0 : a+1).
  - inc and sel together: both act. The increment applies to the pre-advance digit; the pointer then advances.
- CONVERT:
  - One digit per clock, most significant first: acc <= acc*10 + snap[DIGITS-1-step].
  - acc*10 is formed as (acc<<3)+(acc<<1). acc width is clog2(10^DIGITS) so it never overflows.
  - After DIGITS steps: load_value <= (acc_final > MAX_VAL ? MAX_VAL : acc_final) truncated to BIN_W; load_valid <= 1; go to OFFER.
  - Latency: load_valid is high exactly DIGITS cycles after the edge that sampled enter_pulse.
- OFFER:
  - load_valid held at 1 and load_value held stable until load_ready is sampled high.
  - On that edge: load_valid <= 0, go to EDIT. load_value keeps its last value.
  - load_ready is ignored outside OFFER.
- In CONVERT and OFFER, inc/sel/enter pulses are dropped, not queued. digit_bcd and active_digit do not change.
- digit_bcd persists after a load, so the next entry starts from the last value.
- busy = (state != EDIT).

Decomposition:
- Shared package/include holds:
  - state encoding localparams (ST_EDIT, ST_CONVERT, ST_OFFER);
  - the BCD digit width constant (4);
  - the decimal radix constant (10).
- One sub-module: bcd_to_bin_serial.
  - Inputs: start, snapshot bus.
  - Outputs: done, result.
  - Contains the accumulator and step counter.
- The parent holds the digit registers, pointer, FSM and handshake.

Test Plan:
1. Reset then idle: digit_bcd=0x00, active_digit=0, load_valid=0, busy=0; pulses during rst high have no effect.
2. Nominal entry:
   - Stimulus: 7×inc, sel, 4×inc, enter, load_ready=1.
   - Digit response: digit_bcd=0x47.
   - Handshake response: load_valid rises 2 cycles after enter with load_value=47 (7'h2F), falls the cycle after, busy=0.
3. Wrap-around: 10×inc on units -> units returns to 0; 2×sel with DIGITS=2 -> active_digit back to 0.
4. Backpressure and ignored inputs: enter with load_ready=0 for 6 cycles while pulsing inc/sel/enter -> load_value constant, digits and active_digit unchanged; load_ready=1 -> single accept, back to EDIT.
5. Collisions:
   - inc+sel in the same cycle at digits 0x00, pointer 0 -> digits 0x01, active_digit=1.
   - enter+inc in the same cycle -> digits unchanged, conversion starts.
6. Reset mid-CONVERT and saturation:
   - rst during step 1 -> reset values next cycle, no load_valid ever seen.
   - With DIGITS=3, BIN_W=7, MAX_VAL=127, enter 999 -> load_value=127 after 3 cycles.
